// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered into the ALU. The result is captured after a settle time and returned with a DONE pulse.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6,
  parameter int MUL_LAT    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic [DATA_WIDTH-1:0] OP1_0,
  input  logic [DATA_WIDTH-1:0] OP2_0,
  input  logic [OPRN_WIDTH-1:0] OPRN_0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] OP1_1,
  input  logic [DATA_WIDTH-1:0] OP2_1,
  input  logic [OPRN_WIDTH-1:0] OPRN_1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RES,
  output logic                  RES_ZERO,
  output logic                  ERR,
  output logic                  BUSY,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO
);

  // state | meaning
  // IDLE  | waiting for a request, arbitrates on every edge
  // EXEC  | operands held on the ALU, counting down the settle time
  // DONE  | DONEx pulse cycle, result and error flag valid
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(6'h20);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(6'h22);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(6'h2c);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(6'h02);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(6'h01);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6'h24);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(6'h25);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(6'h27);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(6'h2a);

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  res_zero_q, res_zero_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [OPRN_WIDTH-1:0] alu_oprn_q, alu_oprn_d;

  logic                  sel;
  logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
  logic [OPRN_WIDTH-1:0] sel_oprn;
  logic                  sel_valid;

  // On a tie the port that was not served last wins.
  always_comb begin
    sel      = (REQ0 && REQ1) ? ~last_q : REQ1;
    sel_op1  = sel ? OP1_1  : OP1_0;
    sel_op2  = sel ? OP2_1  : OP2_0;
    sel_oprn = sel ? OPRN_1 : OPRN_0;
    case (sel_oprn)
      OP_ADD, OP_SUB, OP_MUL, OP_SRL, OP_SLL,
      OP_AND, OP_OR, OP_NOR, OP_SLT: sel_valid = 1'b1;
      default:                       sel_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = 1'b0;
    res_d      = res_q;
    res_zero_d = res_zero_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    alu_oprn_d = alu_oprn_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          last_d = sel;
          port_d = sel;
          gnt0_d = ~sel;
          gnt1_d = sel;
          if (sel_valid) begin
            alu_op1_d  = sel_op1;
            alu_op2_d  = sel_op2;
            alu_oprn_d = sel_oprn;
            cnt_d      = (sel_oprn == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            state_d    = ST_EXEC;
          end else begin
            // Rejected opcodes skip EXEC, so GNT and DONE land in the same cycle.
            err_d   = 1'b1;
            res_d   = '0;
            done0_d = ~sel;
            done1_d = sel;
            state_d = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_d      = ALU_OUT;
          res_zero_d = ALU_ZERO;
          done0_d    = ~port_q;
          done1_d    = port_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      port_q     <= 1'b0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_oprn_q <= OP_ADD;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err_q      <= err_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
      alu_oprn_q <= alu_oprn_d;
    end
  end

  assign GNT0     = gnt0_q;
  assign GNT1     = gnt1_q;
  assign DONE0    = done0_q;
  assign DONE1    = done1_q;
  assign ERR      = err_q;
  assign RES      = res_q;
  assign RES_ZERO = res_zero_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign ALU_OP1  = alu_op1_q;
  assign ALU_OP2  = alu_op2_q;
  assign ALU_OPRN = alu_oprn_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU behind the arbiter.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_alu_arbiter;

  logic        CLK, RST;
  logic        REQ0, REQ1;
  logic [31:0] OP1_0, OP2_0, OP1_1, OP2_1;
  logic [5:0]  OPRN_0, OPRN_1;
  logic        GNT0, GNT1, DONE0, DONE1;
  logic [31:0] RES;
  logic        RES_ZERO, ERR, BUSY;
  logic [31:0] ALU_OP1, ALU_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .MUL_LAT(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .OP1_0(OP1_0), .OP2_0(OP2_0), .OPRN_0(OPRN_0),
    .REQ1(REQ1), .OP1_1(OP1_1), .OP2_1(OP2_1), .OPRN_1(OPRN_1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .RES(RES), .RES_ZERO(RES_ZERO), .ERR(ERR), .BUSY(BUSY),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO)
  );

  always_comb begin
    case (ALU_OPRN)
      6'h20:   ALU_OUT = ALU_OP1 + ALU_OP2;
      6'h22:   ALU_OUT = ALU_OP1 - ALU_OP2;
      6'h2c:   ALU_OUT = ALU_OP1 * ALU_OP2;
      6'h02:   ALU_OUT = ALU_OP1 >> ALU_OP2;
      6'h01:   ALU_OUT = ALU_OP1 << ALU_OP2;
      6'h24:   ALU_OUT = ALU_OP1 & ALU_OP2;
      6'h25:   ALU_OUT = ALU_OP1 | ALU_OP2;
      6'h27:   ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'h2a:   ALU_OUT = (ALU_OP1 < ALU_OP2) ? 32'd1 : 32'd0;
      default: ALU_OUT = 32'd0;
    endcase
    ALU_ZERO = (ALU_OUT == 32'd0);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    REQ0 = 1'b0; OP1_0 = '0; OP2_0 = '0; OPRN_0 = 6'h20;
    REQ1 = 1'b0; OP1_1 = '0; OP2_1 = '0; OPRN_1 = 6'h20;

    // reset values
    tick(); tick();
    chk1 ("rst_gnt0", GNT0, 1'b0);
    chk1 ("rst_busy", BUSY, 1'b0);
    chk1 ("rst_done0", DONE0, 1'b0);
    chk32("rst_res", RES, 32'd0);
    chk32("rst_oprn", 32'(ALU_OPRN), 32'h20);
    chk32("rst_op1", ALU_OP1, 32'd0);
    RST = 1'b0;

    // single add on port 0
    REQ0 = 1'b1; OP1_0 = 32'd7; OP2_0 = 32'd5; OPRN_0 = 6'h20;
    tick();
    chk1 ("add_gnt0", GNT0, 1'b1);
    chk1 ("add_gnt1", GNT1, 1'b0);
    chk1 ("add_busy_g", BUSY, 1'b1);
    chk1 ("add_done_early", DONE0, 1'b0);
    chk32("add_aluop1", ALU_OP1, 32'd7);
    REQ0 = 1'b0;
    tick();
    chk1 ("add_done0", DONE0, 1'b1);
    chk1 ("add_gnt0_clr", GNT0, 1'b0);
    chk32("add_res", RES, 32'd12);
    chk1 ("add_zero", RES_ZERO, 1'b0);
    chk1 ("add_err", ERR, 1'b0);
    chk1 ("add_busy_d", BUSY, 1'b1);
    tick();
    chk1 ("add_done_clr", DONE0, 1'b0);
    chk1 ("add_idle", BUSY, 1'b0);
    chk32("add_res_hold", RES, 32'd12);

    // tie from reset, requests held throughout
    RST = 1'b1;
    REQ0 = 1'b1; OP1_0 = 32'd9;   OP2_0 = 32'd9;   OPRN_0 = 6'h22;
    REQ1 = 1'b1; OP1_1 = 32'h0F;  OP2_1 = 32'hF0;  OPRN_1 = 6'h25;
    tick();
    RST = 1'b0;
    tick();
    chk1 ("tie1_gnt0", GNT0, 1'b1);
    chk1 ("tie1_gnt1", GNT1, 1'b0);
    tick();
    chk1 ("tie1_done0", DONE0, 1'b1);
    chk1 ("tie1_done1", DONE1, 1'b0);
    chk32("tie1_res", RES, 32'd0);
    chk1 ("tie1_zero", RES_ZERO, 1'b1);
    tick();
    chk1 ("tie1_idle", BUSY, 1'b0);
    tick();
    chk1 ("tie2_gnt1", GNT1, 1'b1);
    chk1 ("tie2_gnt0", GNT0, 1'b0);
    tick();
    chk1 ("tie2_done1", DONE1, 1'b1);
    chk1 ("tie2_done0", DONE0, 1'b0);
    chk32("tie2_res", RES, 32'hFF);
    chk1 ("tie2_zero", RES_ZERO, 1'b0);
    tick();
    tick();
    chk1 ("tie3_gnt0", GNT0, 1'b1);
    chk1 ("tie3_gnt1", GNT1, 1'b0);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    chk1 ("tie3_done0", DONE0, 1'b1);
    tick();

    // multiply on port 1, operand changes after grant must not reach the ALU
    REQ1 = 1'b1; OP1_1 = 32'd6; OP2_1 = 32'd7; OPRN_1 = 6'h2c;
    tick();
    chk1 ("mul_gnt1", GNT1, 1'b1);
    chk32("mul_oprn", 32'(ALU_OPRN), 32'h2c);
    REQ1 = 1'b0; OP1_1 = 32'd99; OP2_1 = 32'd99; OPRN_1 = 6'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1 ("mul_done_early", DONE1, 1'b0);
      chk32("mul_op1_hold", ALU_OP1, 32'd6);
      chk32("mul_op2_hold", ALU_OP2, 32'd7);
      chk1 ("mul_busy", BUSY, 1'b1);
    end
    tick();
    chk1 ("mul_done1", DONE1, 1'b1);
    chk32("mul_res", RES, 32'd42);
    tick();
    chk1 ("mul_idle", BUSY, 1'b0);

    // unsupported opcode on port 0
    REQ0 = 1'b1; OP1_0 = 32'd123; OP2_0 = 32'd1; OPRN_0 = 6'h3f;
    tick();
    chk1 ("inv_gnt0", GNT0, 1'b1);
    chk1 ("inv_done0", DONE0, 1'b1);
    chk1 ("inv_err", ERR, 1'b1);
    chk32("inv_res", RES, 32'd0);
    chk32("inv_oprn", 32'(ALU_OPRN), 32'h2c);
    chk32("inv_op1", ALU_OP1, 32'd6);
    REQ0 = 1'b0;
    tick();
    chk1 ("inv_done_clr", DONE0, 1'b0);
    chk1 ("inv_err_clr", ERR, 1'b0);
    chk1 ("inv_idle", BUSY, 1'b0);

    // async reset in the middle of a multiply
    REQ1 = 1'b1; OP1_1 = 32'd3; OP2_1 = 32'd3; OPRN_1 = 6'h2c;
    tick();
    chk1 ("ar_gnt1", GNT1, 1'b1);
    REQ1 = 1'b0;
    tick();
    #2;
    RST = 1'b1;
    #1;
    chk1 ("ar_busy", BUSY, 1'b0);
    chk32("ar_oprn", 32'(ALU_OPRN), 32'h20);
    chk32("ar_op1", ALU_OP1, 32'd0);
    tick();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1 ("ar_no_done1", DONE1, 1'b0);
      chk1 ("ar_no_busy", BUSY, 1'b0);
    end
    REQ0 = 1'b1; OP1_0 = 32'd1; OP2_0 = 32'd2; OPRN_0 = 6'h20;
    REQ1 = 1'b1; OP1_1 = 32'd4; OP2_1 = 32'd4; OPRN_1 = 6'h25;
    tick();
    chk1 ("ar_tie_gnt0", GNT0, 1'b1);
    chk1 ("ar_tie_gnt1", GNT1, 1'b0);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    chk1 ("ar_tie_done0", DONE0, 1'b1);
    chk32("ar_tie_res", RES, 32'd3);
    tick();

    // port 1 arriving while port 0 is executing
    REQ0 = 1'b1; OP1_0 = 32'd1; OP2_0 = 32'd4; OPRN_0 = 6'h01;
    tick();
    chk1 ("late_gnt0", GNT0, 1'b1);
    REQ0 = 1'b0;
    REQ1 = 1'b1; OP1_1 = 32'd100; OP2_1 = 32'd1; OPRN_1 = 6'h20;
    tick();
    chk1 ("late_done0", DONE0, 1'b1);
    chk32("late_res0", RES, 32'd16);
    chk1 ("late_gnt1_exec", GNT1, 1'b0);
    tick();
    chk1 ("late_gnt1_done", GNT1, 1'b0);
    tick();
    chk1 ("late_gnt1", GNT1, 1'b1);
    chk32("late_aluop1", ALU_OP1, 32'd100);
    REQ1 = 1'b0;
    tick();
    chk1 ("late_done1", DONE1, 1'b1);
    chk32("late_res1", RES, 32'd101);
    tick();
    chk1 ("late_idle", BUSY, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
